// File: rtl/mips_busif.sv
`default_nettype none
// mips_busif: bus master handshake engine between the multicycle MIPS controller and the arbitrated memory bus.
// Optional macro BUSIF_TIMEOUT_EN adds an abort counter over the REQ and XFER states.
module mips_busif #(
    parameter int WIDTH   = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cpu_req,
    input  logic                 cpu_we,
    input  logic [1:0]           cpu_size,
    input  logic                 cpu_signed,
    input  logic [ADDR_W-1:0]    cpu_adr,
    input  logic [WIDTH-1:0]     cpu_wdata,
    output logic [WIDTH-1:0]     cpu_rdata,
    output logic                 cpu_ack,
    output logic                 cpu_err,
    output logic                 breq_,
    input  logic                 bgrt_,
    output logic                 done,
    output logic [ADDR_W-1:0]    bus_adr,
    output logic [WIDTH-1:0]     bus_wdata,
    input  logic [WIDTH-1:0]     bus_rdata,
    output logic                 bus_read,
    output logic                 bus_write,
    output logic [WIDTH/8-1:0]   bus_ben,
    input  logic                 bus_rdy
);
    localparam int NB = WIDTH / 8;
    localparam int LW = $clog2(NB);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] XFER = 2'd2;
    localparam logic [1:0] FIN  = 2'd3;

    logic [1:0]        state;
    logic [ADDR_W-1:0] adr;
    logic              we;
    logic              sgn;
    logic [1:0]        size;
    logic [WIDTH-1:0]  wdata;

    logic [LW-1:0]     lane;
    logic [NB-1:0]     ben_c;
    logic [WIDTH-1:0]  wdata_c;
    logic [WIDTH-1:0]  rdata_c;
    logic [2:0]        amask;
    logic              req_bad;
    logic              sbit;
    logic              tmo_hit;
    int                nb;

    always_comb begin
        lane    = adr[LW-1:0];
        nb      = 1 << size;
        if (nb > NB) nb = NB;
        ben_c   = '0;
        wdata_c = '0;
        rdata_c = '0;
        for (int i = 0; i < NB; i++) begin
            if ((i >= int'(lane)) && (i < int'(lane) + nb)) ben_c[i] = 1'b1;
            wdata_c[i*8 +: 8] = wdata[(i % nb)*8 +: 8];
            if (i < nb) rdata_c[i*8 +: 8] = bus_rdata[((i + int'(lane)) % NB)*8 +: 8];
        end
        // Extend above the accessed bytes; a full-width access has nothing to extend.
        sbit = rdata_c[nb*8-1];
        for (int i = 0; i < NB; i++) begin
            if (i >= nb) rdata_c[i*8 +: 8] = {8{sgn & sbit}};
        end
    end

    always_comb begin
        amask   = (3'd1 << cpu_size) - 3'd1;
        req_bad = (int'(cpu_size) > LW) || (|(cpu_adr[2:0] & amask));
    end

`ifdef BUSIF_TIMEOUT_EN
    localparam int TB = $clog2(TIMEOUT + 1);
    localparam int CW = (TB < 8) ? 8 : ((TB > 16) ? 16 : TB);

    logic [CW-1:0] tcnt;

    always_ff @(posedge clk) begin
        if (reset || state == IDLE) begin
            tcnt <= '0;
        end else if (state == REQ || state == XFER) begin
            tcnt <= tcnt + 1'b1;
        end
    end

    assign tmo_hit = (state == REQ || state == XFER) && (tcnt == CW'(TIMEOUT - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            adr       <= '0;
            we        <= 1'b0;
            sgn       <= 1'b0;
            size      <= 2'd0;
            wdata     <= '0;
            cpu_rdata <= '0;
            cpu_ack   <= 1'b0;
            cpu_err   <= 1'b0;
            breq_     <= 1'b1;
            done      <= 1'b0;
            bus_adr   <= '0;
            bus_wdata <= '0;
            bus_read  <= 1'b0;
            bus_write <= 1'b0;
            bus_ben   <= '0;
        end else begin
            cpu_ack <= 1'b0;
            cpu_err <= 1'b0;
            done    <= 1'b0;
            case (state)
                IDLE: begin
                    if (cpu_req) begin
                        adr   <= cpu_adr;
                        we    <= cpu_we;
                        sgn   <= cpu_signed;
                        size  <= cpu_size;
                        wdata <= cpu_wdata;
                        // Rejected accesses never touch the bus and skip the done pulse.
                        if (req_bad) begin
                            state     <= FIN;
                            cpu_ack   <= 1'b1;
                            cpu_err   <= 1'b1;
                            cpu_rdata <= '0;
                        end else begin
                            state <= REQ;
                            breq_ <= 1'b0;
                        end
                    end
                end
                REQ: begin
                    if (tmo_hit) begin
                        state     <= FIN;
                        breq_     <= 1'b1;
                        done      <= 1'b1;
                        cpu_ack   <= 1'b1;
                        cpu_err   <= 1'b1;
                        cpu_rdata <= '0;
                    end else if (!bgrt_) begin
                        state     <= XFER;
                        bus_adr   <= {adr[ADDR_W-1:LW], {LW{1'b0}}};
                        bus_ben   <= ben_c;
                        bus_wdata <= wdata_c;
                        bus_read  <= ~we;
                        bus_write <= we;
                    end
                end
                XFER: begin
                    if (tmo_hit || bus_rdy) begin
                        state     <= FIN;
                        breq_     <= 1'b1;
                        done      <= 1'b1;
                        cpu_ack   <= 1'b1;
                        bus_read  <= 1'b0;
                        bus_write <= 1'b0;
                        bus_ben   <= '0;
                        if (tmo_hit) begin
                            cpu_err   <= 1'b1;
                            cpu_rdata <= '0;
                        end else if (!we) begin
                            cpu_rdata <= rdata_c;
                        end
                    end
                end
                FIN: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_mips_busif.sv
`default_nettype none
// tb_mips_busif: table-driven and randomized checks of mips_busif (WIDTH=32) against a byte-level reference model.
module tb_mips_busif;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [1:0]  cpu_size = 2'd0;
    logic        cpu_signed = 1'b0;
    logic [31:0] cpu_adr = '0;
    logic [31:0] cpu_wdata = '0;
    logic [31:0] cpu_rdata;
    logic        cpu_ack;
    logic        cpu_err;
    logic        breq_;
    logic        bgrt_ = 1'b1;
    logic        done;
    logic [31:0] bus_adr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata = '0;
    logic        bus_read;
    logic        bus_write;
    logic [3:0]  bus_ben;
    logic        bus_rdy = 1'b0;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mips_busif #(.WIDTH(32), .ADDR_W(32), .TIMEOUT(10)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_size(cpu_size), .cpu_signed(cpu_signed),
        .cpu_adr(cpu_adr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
        .cpu_ack(cpu_ack), .cpu_err(cpu_err),
        .breq_(breq_), .bgrt_(bgrt_), .done(done),
        .bus_adr(bus_adr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
        .bus_read(bus_read), .bus_write(bus_write), .bus_ben(bus_ben), .bus_rdy(bus_rdy)
    );

    typedef struct {
        bit          we;
        logic [1:0]  size;
        bit          sgn;
        logic [31:0] adr;
        logic [31:0] wdata;
        logic [31:0] brd;
        int          gd;
        int          ws;
        logic [3:0]  ben;
        logic [31:0] bwd;
        logic [31:0] rd;
        bit          err;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: treat words as byte arrays, little-endian.
    function automatic vec_t model(input vec_t v);
        int n;
        int lane;
        logic [31:0] val;
        n = 1 << v.size;
        lane = int'(v.adr[1:0]);
        v.err = (v.size == 2'd3) || ((v.adr % n) != 0);
        v.ben = '0;
        v.bwd = '0;
        v.rd  = '0;
        if (!v.err) begin
            for (int k = 0; k < n; k++) v.ben[lane + k] = 1'b1;
            for (int b = 0; b < 4; b++) v.bwd[b*8 +: 8] = v.wdata[(b % n)*8 +: 8];
            val = '0;
            for (int k = 0; k < n; k++) val[k*8 +: 8] = v.brd[(lane + k)*8 +: 8];
            if (v.sgn && n < 4 && val[8*n-1]) begin
                for (int k = n; k < 4; k++) val[k*8 +: 8] = 8'hFF;
            end
            v.rd = val;
        end
        return v;
    endfunction

    task automatic run(input vec_t v, input int exp_lat, input bit exp_xfer);
        int cyc = 0;
        int rc = 0;
        int wc = 0;
        int dones = 0;
        int breq_hi = 0;
        bit seen = 0;
        bit acked = 0;
        bit exp_req;
        logic [3:0]  ben_s = '0;
        logic [31:0] adr_s = '0;
        logic [31:0] wd_s = '0;
        bit rd_s = 0;
        bit wr_s = 0;
        exp_req = (exp_lat > 1);
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = v.we; cpu_size = v.size; cpu_signed = v.sgn;
        cpu_adr = v.adr; cpu_wdata = v.wdata; bus_rdata = v.brd; bgrt_ = 1'b1; bus_rdy = 1'b0;
        while (cyc < 300 && !acked) begin
            @(negedge clk);
            cyc++;
            cpu_req = 1'b0;
            if (cpu_ack) begin
                acked = 1;
            end else begin
                if (done) dones++;
                if (breq_) breq_hi++;
                if (bus_read || bus_write) begin
                    if (!seen) begin
                        seen = 1; ben_s = bus_ben; adr_s = bus_adr; wd_s = bus_wdata;
                        rd_s = bus_read; wr_s = bus_write;
                    end
                    wc++;
                    bus_rdy = (wc > v.ws);
                end else if (!breq_) begin
                    rc++;
                    bgrt_ = (rc > v.gd) ? 1'b0 : 1'b1;
                end
            end
        end
        bgrt_ = 1'b1;
        bus_rdy = 1'b0;
        chk("ack_seen", 64'(acked), 64'd1);
        chk("latency", 64'(cyc), 64'(exp_lat));
        chk("err", 64'(cpu_err), 64'(v.err));
        if (!v.we || v.err) chk("rdata", 64'(cpu_rdata), 64'(v.rd));
        chk("done_at_ack", 64'(done), 64'(exp_req));
        chk("early_done", 64'(dones), 64'd0);
        if (exp_req) chk("breq_held", 64'(breq_hi), 64'd0);
        else chk("no_breq", 64'(rc), 64'd0);
        chk("xfer_seen", 64'(seen), 64'(exp_xfer));
        if (exp_xfer) begin
            chk("ben", 64'(ben_s), 64'(v.ben));
            chk("bus_adr", 64'(adr_s), 64'(v.adr & 32'hFFFF_FFFC));
            chk("dir_read", 64'(rd_s), 64'(!v.we));
            chk("dir_write", 64'(wr_s), 64'(v.we));
            if (v.we) chk("bus_wdata", 64'(wd_s), 64'(v.bwd));
        end
        chk("breq_at_ack", 64'(breq_), 64'd1);
        chk("strobe_at_ack", 64'(bus_read | bus_write), 64'd0);
        chk("ben_at_ack", 64'(bus_ben), 64'd0);
        @(negedge clk);
        chk("ack_pulse", 64'(cpu_ack), 64'd0);
        chk("done_pulse", 64'(done), 64'd0);
        if (!v.we || v.err) chk("rdata_hold", 64'(cpu_rdata), 64'(v.rd));
    endtask

    vec_t tbl[8];
    vec_t v;

    initial begin
        // Hand-written vectors with independently derived expectations.
        tbl[0] = '{0, 2'd2, 0, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0, 4'b1111, 32'h0, 32'hDEADBEEF, 0};
        tbl[1] = '{0, 2'd0, 1, 32'h103, 32'h0, 32'h80FF0000, 0, 0, 4'b1000, 32'h0, 32'hFFFFFF80, 0};
        tbl[2] = '{0, 2'd0, 0, 32'h103, 32'h0, 32'h80FF0000, 0, 0, 4'b1000, 32'h0, 32'h00000080, 0};
        tbl[3] = '{1, 2'd1, 0, 32'h202, 32'h1234, 32'h0, 5, 3, 4'b1100, 32'h12341234, 32'h0, 0};
        tbl[4] = '{0, 2'd2, 0, 32'h101, 32'h0, 32'h0, 0, 0, 4'b0000, 32'h0, 32'h0, 1};
        tbl[5] = '{0, 2'd1, 1, 32'h002, 32'h0, 32'h80017FFF, 1, 2, 4'b1100, 32'h0, 32'hFFFF8001, 0};
        tbl[6] = '{1, 2'd0, 0, 32'h001, 32'h55AB, 32'h0, 2, 0, 4'b0010, 32'hABABABAB, 32'h0, 0};
        tbl[7] = '{0, 2'd3, 0, 32'h000, 32'h0, 32'h0, 0, 0, 4'b0000, 32'h0, 32'h0, 1};

        repeat (3) @(negedge clk);
        chk("rst_breq", 64'(breq_), 64'd1);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_ack", 64'(cpu_ack), 64'd0);
        chk("rst_err", 64'(cpu_err), 64'd0);
        chk("rst_rdata", 64'(cpu_rdata), 64'd0);
        chk("rst_strobes", 64'({bus_read, bus_write}), 64'd0);
        chk("rst_ben", 64'(bus_ben), 64'd0);
        chk("rst_adr", 64'(bus_adr), 64'd0);
        chk("rst_wdata", 64'(bus_wdata), 64'd0);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) begin
            run(tbl[i], tbl[i].err ? 1 : 3 + tbl[i].gd + tbl[i].ws, !tbl[i].err);
        end

        for (int i = 0; i < 40; i++) begin
            v = '{default: '0};
            v.we = 1'($urandom_range(0, 1));
            v.size = 2'($urandom_range(0, 3));
            v.sgn = 1'($urandom_range(0, 1));
            v.adr = $urandom;
            if ($urandom_range(0, 3) != 0) v.adr = v.adr & ~((32'd1 << v.size) - 32'd1);
            v.wdata = $urandom;
            v.brd = $urandom;
            v.gd = $urandom_range(0, 3);
            v.ws = $urandom_range(0, 3);
            v = model(v);
            run(v, v.err ? 1 : 3 + v.gd + v.ws, !v.err);
        end

        // Reset while the bus transfer is in progress.
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_size = 2'd2; cpu_adr = 32'h40; bgrt_ = 1'b1; bus_rdy = 1'b0;
        @(negedge clk);
        cpu_req = 1'b0; bgrt_ = 1'b0;
        @(negedge clk);
        chk("xfer_before_reset", 64'(bus_read), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_breq", 64'(breq_), 64'd1);
        chk("mid_rst_read", 64'(bus_read), 64'd0);
        chk("mid_rst_ack", 64'(cpu_ack), 64'd0);
        chk("mid_rst_done", 64'(done), 64'd0);
        reset = 1'b0; bgrt_ = 1'b1;
        begin
            int spurious = 0;
            repeat (3) begin
                @(negedge clk);
                if (cpu_ack || done || !breq_) spurious++;
            end
            chk("post_rst_quiet", 64'(spurious), 64'd0);
        end
        run(tbl[0], 3, 1);

        // Grant withheld for a long time.
        v = tbl[0];
        v.gd = 20;
`ifdef BUSIF_TIMEOUT_EN
        v.err = 1;
        v.rd = '0;
        run(v, 11, 0);
`else
        run(v, 23, 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
